// File: rtl/firo_ctrl_pkg.sv
// Shared constants, state encoding and counter sizing helper for the FIRO sampler.
package firo_ctrl_pkg;

    localparam int unsigned WORD_W_DEF        = 32;
    localparam int unsigned WARMUP_CYCLES_DEF = 256;
    localparam int unsigned DECIM_DEF         = 4;
    localparam int unsigned RCT_CUTOFF_DEF    = 21;
    localparam int unsigned APT_WIN_DEF       = 512;
    localparam int unsigned APT_CUTOFF_DEF    = 410;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WARMUP = 3'd1;
    localparam state_t ST_SAMPLE = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_FAIL   = 3'd4;

    // Counter width able to hold the value n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/firo_health_test.sv
// Continuous repetition-count and adaptive-proportion tests on captured raw bits.
module firo_health_test
    import firo_ctrl_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int unsigned APT_WIN    = APT_WIN_DEF,
    parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    output logic fail_pulse
);

    localparam int unsigned RCT_W = cnt_w(RCT_CUTOFF);
    localparam int unsigned APT_W = cnt_w(APT_WIN);

    logic [RCT_W-1:0] r_rct_cnt, w_rct_cnt;
    logic             r_rct_bit, w_rct_bit;
    logic [APT_W-1:0] r_apt_pos, w_apt_pos;
    logic [APT_W-1:0] r_apt_cnt, w_apt_cnt;
    logic             r_apt_ref, w_apt_ref;
    logic             r_fail_pulse, w_fail;

    // Next-state of both tests for the bit presented this cycle.
    always_comb begin
        w_rct_cnt = r_rct_cnt;
        w_rct_bit = r_rct_bit;
        w_apt_pos = r_apt_pos;
        w_apt_cnt = r_apt_cnt;
        w_apt_ref = r_apt_ref;
        w_fail    = 1'b0;
        if (bit_vld) begin
            w_rct_bit = bit_in;
            if (r_rct_cnt == '0 || bit_in != r_rct_bit) begin
                w_rct_cnt = RCT_W'(1);
            end else if (r_rct_cnt < RCT_W'(RCT_CUTOFF)) begin
                w_rct_cnt = r_rct_cnt + RCT_W'(1);
            end
            // Position 0 marks the first sample of a window; it becomes the reference.
            if (r_apt_pos == '0) begin
                w_apt_ref = bit_in;
                w_apt_cnt = APT_W'(1);
            end else if (bit_in == r_apt_ref && r_apt_cnt < APT_W'(APT_WIN)) begin
                w_apt_cnt = r_apt_cnt + APT_W'(1);
            end
            w_apt_pos = (r_apt_pos == APT_W'(APT_WIN - 1)) ? '0 : r_apt_pos + APT_W'(1);
            w_fail    = (w_rct_cnt == RCT_W'(RCT_CUTOFF)) || (w_apt_cnt == APT_W'(APT_CUTOFF));
        end
    end

    // Test state registers; clr restarts both tests from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rct_cnt    <= '0;
            r_rct_bit    <= 1'b0;
            r_apt_pos    <= '0;
            r_apt_cnt    <= '0;
            r_apt_ref    <= 1'b0;
            r_fail_pulse <= 1'b0;
        end else if (clr) begin
            r_rct_cnt    <= '0;
            r_rct_bit    <= 1'b0;
            r_apt_pos    <= '0;
            r_apt_cnt    <= '0;
            r_apt_ref    <= 1'b0;
            r_fail_pulse <= 1'b0;
        end else begin
            r_rct_cnt    <= w_rct_cnt;
            r_rct_bit    <= w_rct_bit;
            r_apt_pos    <= w_apt_pos;
            r_apt_cnt    <= w_apt_cnt;
            r_apt_ref    <= w_apt_ref;
            r_fail_pulse <= w_fail;
        end
    end

    assign fail_pulse = r_fail_pulse;

endmodule

// File: rtl/firo_sampler_ctrl.sv
// Sequencer for one Fibonacci ring oscillator: warm-up, decimated capture, word packing, health gating.
module firo_sampler_ctrl
    import firo_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W        = WORD_W_DEF,
    parameter int unsigned WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int unsigned DECIM         = DECIM_DEF,
    parameter int unsigned RCT_CUTOFF    = RCT_CUTOFF_DEF,
    parameter int unsigned APT_WIN       = APT_WIN_DEF,
    parameter int unsigned APT_CUTOFF    = APT_CUTOFF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              osc_en,
    output logic              dff_en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              fail
);

    localparam int unsigned WU_W = cnt_w(WARMUP_CYCLES);
    localparam int unsigned DC_W = cnt_w(DECIM);
    localparam int unsigned BC_W = cnt_w(WORD_W);

    state_t            r_state, w_state;
    logic              r_osc_en, w_osc_en;
    logic              r_dff_en, w_dff_en;
    logic              r_cap, w_cap;
    logic [WORD_W-1:0] r_word_data, w_word_data;
    logic              r_word_valid, w_word_valid;
    logic              r_busy, w_busy;
    logic              r_fail, w_fail;
    logic [WU_W-1:0]   r_wu_cnt, w_wu_cnt;
    logic [DC_W-1:0]   r_dc_cnt, w_dc_cnt;
    logic [BC_W-1:0]   r_bc_cnt, w_bc_cnt;
    logic              r_done, w_done;
    logic              w_clr;
    logic              w_bit_vld;
    logic              w_fail_pulse;

    // raw_bit is valid the cycle after the strobe cycle; r_cap tracks that.
    assign w_bit_vld = r_cap && (r_state == ST_SAMPLE);

    firo_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WIN    (APT_WIN),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_clr),
        .bit_vld    (w_bit_vld),
        .bit_in     (raw_bit),
        .fail_pulse (w_fail_pulse)
    );

    // Next-state and next-output logic. A completed word waits one cycle in r_done
    // so that a health failure on its last bit pre-empts word_valid.
    always_comb begin
        w_state      = r_state;
        w_osc_en     = r_osc_en;
        w_dff_en     = 1'b0;
        w_cap        = r_dff_en;
        w_word_data  = r_word_data;
        w_word_valid = r_word_valid;
        w_fail       = r_fail;
        w_wu_cnt     = r_wu_cnt;
        w_dc_cnt     = r_dc_cnt;
        w_bc_cnt     = r_bc_cnt;
        w_done       = r_done;
        w_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_osc_en     = 1'b0;
                w_word_valid = 1'b0;
                w_fail       = 1'b0;
                if (enable) begin
                    w_state     = ST_WARMUP;
                    w_osc_en    = 1'b1;
                    w_wu_cnt    = '0;
                    w_dc_cnt    = '0;
                    w_bc_cnt    = '0;
                    w_done      = 1'b0;
                    w_word_data = '0;
                    w_clr       = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    w_state  = ST_IDLE;
                    w_osc_en = 1'b0;
                end else if (r_wu_cnt == WU_W'(WARMUP_CYCLES - 1)) begin
                    w_state  = ST_SAMPLE;
                    w_dc_cnt = '0;
                end else begin
                    w_wu_cnt = r_wu_cnt + WU_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (w_fail_pulse) begin
                    w_state      = ST_FAIL;
                    w_osc_en     = 1'b0;
                    w_word_valid = 1'b0;
                    w_fail       = 1'b1;
                    w_word_data  = '0;
                    w_done       = 1'b0;
                end else if (!enable) begin
                    w_state      = ST_IDLE;
                    w_osc_en     = 1'b0;
                    w_word_valid = 1'b0;
                end else if (r_done) begin
                    w_state      = ST_WAIT;
                    w_word_valid = 1'b1;
                    w_done       = 1'b0;
                end else begin
                    if (w_bit_vld) begin
                        w_word_data = {r_word_data[WORD_W-2:0], raw_bit};
                        if (r_bc_cnt == BC_W'(WORD_W)) begin
                            w_done = 1'b1;
                        end
                    end
                    // r_bc_cnt counts strobes issued; stop once the word is fully requested.
                    if (r_bc_cnt < BC_W'(WORD_W)) begin
                        if (r_dc_cnt == DC_W'(DECIM - 1)) begin
                            w_dff_en = 1'b1;
                            w_dc_cnt = '0;
                            w_bc_cnt = r_bc_cnt + BC_W'(1);
                        end else begin
                            w_dc_cnt = r_dc_cnt + DC_W'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (w_fail_pulse) begin
                    w_state      = ST_FAIL;
                    w_osc_en     = 1'b0;
                    w_word_valid = 1'b0;
                    w_fail       = 1'b1;
                    w_word_data  = '0;
                end else if (!enable) begin
                    w_state      = ST_IDLE;
                    w_osc_en     = 1'b0;
                    w_word_valid = 1'b0;
                end else if (r_word_valid && word_ready) begin
                    w_state      = ST_SAMPLE;
                    w_word_valid = 1'b0;
                    w_bc_cnt     = '0;
                    w_dc_cnt     = '0;
                end
            end
            ST_FAIL: begin
                w_osc_en     = 1'b0;
                w_word_valid = 1'b0;
                w_fail       = 1'b1;
                if (!enable) begin
                    w_state = ST_IDLE;
                    w_fail  = 1'b0;
                end
            end
            default: begin
                w_state      = ST_IDLE;
                w_osc_en     = 1'b0;
                w_word_valid = 1'b0;
            end
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_osc_en     <= 1'b0;
            r_dff_en     <= 1'b0;
            r_cap        <= 1'b0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
            r_wu_cnt     <= '0;
            r_dc_cnt     <= '0;
            r_bc_cnt     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_osc_en     <= w_osc_en;
            r_dff_en     <= w_dff_en;
            r_cap        <= w_cap;
            r_word_data  <= w_word_data;
            r_word_valid <= w_word_valid;
            r_busy       <= w_busy;
            r_fail       <= w_fail;
            r_wu_cnt     <= w_wu_cnt;
            r_dc_cnt     <= w_dc_cnt;
            r_bc_cnt     <= w_bc_cnt;
            r_done       <= w_done;
        end
    end

    assign osc_en     = r_osc_en;
    assign dff_en     = r_dff_en;
    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign busy       = r_busy;
    assign fail       = r_fail;

endmodule

// File: doc/firo_sampler_ctrl.md
Name: firo_sampler_ctrl

Overview:
Sequencer for one Fibonacci ring oscillator entropy source. Gates the oscillator enable, runs a warm-up period and strobes the oscillator's capture-flop enable at a decimated rate. Packs the sampled raw bits into words and runs continuous health tests on them. Delivers words over a valid/ready interface to the downstream SHA3 conditioner.

Parameters:
WORD_W, 32, bits per output word
WARMUP_CYCLES, 256, clk cycles oscillator runs before first sample (>=1)
DECIM, 4, clk cycles between capture strobes (>=2)
RCT_CUTOFF, 21, repetition-count fail threshold (identical consecutive samples)
APT_WIN, 512, adaptive-proportion window length in samples
APT_CUTOFF, 410, adaptive-proportion fail threshold (matches of window's first sample)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
enable  in  1  level; high = run source, low = stop and return to idle
osc_en  out  1  to oscillator en
dff_en  out  1  to oscillator dff_en; single-cycle capture strobe
raw_bit  in  1  oscillator random_out, synchronous to clk
word_data  out  WORD_W  packed sample word
word_valid  out  1  word_data valid
word_ready  in  1  downstream accepts word
busy  out  1  state != IDLE
fail  out  1  health-test failure, sticky

Behaviour:
- Reset (async, rst=1): state IDLE; osc_en, dff_en, word_valid, fail, busy = 0; word_data = 0; all counters = 0.
- All outputs are registered.
- IDLE: osc_en=0. If enable=1, go to WARMUP next cycle; osc_en rises the same edge.
- WARMUP: osc_en=1; count WARMUP_CYCLES clk cycles, then go to SAMPLE. Health counters and bit counter are cleared on entry. No strobes are issued.
- SAMPLE: dff_en is high for exactly 1 cycle every DECIM cycles; the first strobe comes DECIM cycles after SAMPLE entry.
- raw_bit is captured in the cycle after each strobe (1-cycle capture-flop latency).
- Each captured bit shifts into word_data at bit 0 (word_data <= {word_data[WORD_W-2:0], raw_bit}) and is fed to the health tests.
- After the WORD_W-th capture, go to WAIT with word_valid=1.
- WAIT: no strobes; osc_en stays 1. word_valid and word_data are held stable until word_valid && word_ready.
- On transfer: word_valid=0 and the bit counter is cleared next cycle; state returns to SAMPLE and the strobe cadence restarts (first strobe DECIM cycles later). Health counters persist across words.
- RCT: counts consecutive identical captured bits, with count=1 on the first bit. When the count reaches RCT_CUTOFF, go to FAIL.
- APT: the first bit of each window is the reference. Count bits in the window equal to the reference, including the first. When the count reaches APT_CUTOFF, go to FAIL. The window restarts after APT_WIN samples.
- FAIL: fail=1 (sticky); osc_en=0, dff_en=0, word_valid=0. Any partial or pending word is discarded. Leave for IDLE only when enable=0; fail is cleared on that exit.
- enable=0 in WARMUP, SAMPLE or WAIT: go to IDLE next cycle; osc_en=0, word_valid=0, and any pending word is dropped even if word_ready is high that cycle.
- Simultaneous events:
  - Health fail on the same capture that completes a word: FAIL wins and word_valid never asserts.
  - enable=0 together with a health fail: FAIL wins.
- Widths: counters are sized with $clog2 of their parameter plus 1. APT counts saturate at APT_WIN.

Decomposition:
- Package firo_ctrl_pkg holds the state enum (IDLE, WARMUP, SAMPLE, WAIT, FAIL) and the default parameter constants.
- Sub-module firo_health_test holds RCT and APT. Inputs: clk, rst, clr, bit_vld, bit. Output: registered fail_pulse, one cycle after the offending bit.

Test Plan:
- Reset mid-SAMPLE, with WARMUP_CYCLES=8, DECIM=2, WORD_W=8 and rst asserted asynchronously -> all outputs 0 immediately, state IDLE. After release with enable held 1, osc_en rises 1 cycle later.
- Nominal, same parameters, bench drives raw_bit from the pattern 1,0,1,0,0,1,0,1 on the capture cycles -> first dff_en pulse 8+2 cycles after osc_en rises. Pulses are then spaced 2 cycles apart. word_valid=1 with word_data=0xA5 after the 8th capture, and fail stays 0.
- Backpressure: word_ready=0 for 50 cycles after word_valid -> word_data=0xA5 stable, dff_en=0 throughout. A 1-cycle word_ready gives word_valid=0 next cycle and a new strobe 2 cycles later.
- RCT: raw_bit stuck at 1, RCT_CUTOFF=21 -> fail=1 after the 21st capture, osc_en=0, word_valid never asserted. enable=0 gives fail=0 and IDLE.
- APT: repeating pattern of seven 1s then one 0 (RCT safe), default APT parameters -> fail asserts at the capture where the count of 1s in the window reaches 410, i.e. the 468th sample.
- Abort: enable drops while in WAIT with word_ready=1 in the same cycle -> no transfer, word_valid=0 and osc_en=0 next cycle, busy=0.
